// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: ALU opcodes, block-transfer sequencer states
// and a small popcount helper.
package cpu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_STR = 4'b1001;
    localparam logic [3:0] ALU_LDM = 4'b1010;

    localparam int WORD_BYTES = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        DONE  = ST_DONE
    } seq_state_e;

    function automatic logic [4:0] popcount16(input logic [15:0] m);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, m[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// Combinational priority encoder: index of the lowest set bit of mask plus an
// any-set flag. idx is 0 when mask is empty.
module lowest_set_bit #(
    parameter int NREGS = 16,
    parameter int IDX_W = $clog2(NREGS)
) (
    input  logic [NREGS-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan high to low so the lowest set bit is the final assignment.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Expands one LDM/STM into one ALU address beat per listed register.
// Define LDM_WRITEBACK_EN to build the base-register writeback path.
module ldm_stm_sequencer #(
    parameter int NREGS      = 16,
    parameter int DATA_W     = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic              is_load,
    input  logic              decrement,
    input  logic              writeback,
    input  logic [DATA_W-1:0] base,
    input  logic [NREGS-1:0]  reg_list,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_control,
    output logic [3:0]        reg_idx,
    output logic              last,
    output logic              done,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_base,
    output logic [1:0]        state
);
    import cpu_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // The sequencer holds all op outputs stable while op_valid && !op_ready.
    seq_state_e        state_q;
    logic [NREGS-1:0]  mask;
    logic [4:0]        beat;
    logic [3:0]        idx;
    logic              any;
    logic              accept;
    logic [4:0]        n_start;
    logic [DATA_W-1:0] span;

    lowest_set_bit #(.NREGS(NREGS), .IDX_W(4)) u_lsb (
        .mask (mask),
        .idx  (idx),
        .any  (any)
    );

    assign accept  = start_valid && start_ready;
    assign n_start = popcount16(reg_list);
    assign span    = DATA_W'(n_start) * DATA_W'(WORD_BYTES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mask        <= '0;
            beat        <= '0;
            alu_a       <= '0;
            alu_control <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mask        <= reg_list;
                        beat        <= '0;
                        alu_a       <= decrement ? (base - span) : base;
                        alu_control <= is_load ? ALU_LDM : ALU_STR;
                        state_q     <= (reg_list != '0) ? ISSUE : DONE;
                    end
                end
                ISSUE: begin
                    if (op_ready) begin
                        mask <= mask & ~(NREGS'(1) << idx);
                        beat <= beat + 5'd1;
                        if (last) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state       = state_q;
    assign start_ready = (state_q == IDLE);
    assign op_valid    = (state_q == ISSUE);
    assign done        = (state_q == DONE);
    assign reg_idx     = idx;
    assign alu_b       = DATA_W'(beat) * DATA_W'(WORD_BYTES);
    // Exactly one bit left in the mask means this is the final beat.
    assign last        = op_valid && any && ((mask & (mask - NREGS'(1))) == '0);

`ifdef LDM_WRITEBACK_EN
    logic wb_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_pend <= 1'b0;
            wb_base <= '0;
        end else if (accept) begin
            wb_pend <= writeback && (n_start != 5'd0);
            wb_base <= decrement ? (base - span) : (base + span);
        end
    end

    assign wb_valid = done && wb_pend;
`else
    logic unused_writeback;

    assign unused_writeback = writeback;
    assign wb_valid         = 1'b0;
    assign wb_base          = '0;
`endif

endmodule
